// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp timer with a single-outstanding request/response slave.
// Define CLINT_MSIP_EN to add the msip software-interrupt register and the clint_msip output.
module clint_timer #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned DIV_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        clint_mtip
`ifdef CLINT_MSIP_EN
    ,
    output logic        clint_msip
`endif
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    state_t           state;
    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic [DIV_W-1:0] prescaler;

    logic [63:0]      offset;
    logic [63:0]      wmask;
    logic [63:0]      rdata_next;
    logic [63:0]      mtime_next;
    logic [63:0]      mtimecmp_next;
    logic [DIV_W-1:0] prescaler_next;
    logic             tick;
    logic             accept;
    logic             hit_time;
    logic             hit_cmp;
    logic             hit_msip;
    logic             err_next;

`ifdef CLINT_MSIP_EN
    logic msip;
`endif

    // Decode, tick and next-state computation; a bus write to mtime overrides that cycle's tick.
    always_comb begin
        offset   = req_addr - BASE_ADDR;
        accept   = req_valid && req_ready;
        hit_cmp  = (offset == 64'h4000);
        hit_time = (offset == 64'hBFF8);
`ifdef CLINT_MSIP_EN
        hit_msip = (offset == 64'h0000);
`else
        hit_msip = 1'b0;
`endif
        err_next = (req_addr[2:0] != 3'b000) || !(hit_cmp || hit_time || hit_msip);

        wmask = '0;
        for (int i = 0; i < 8; i++) begin
            wmask[8*i +: 8] = {8{req_wstrb[i]}};
        end

        tick           = (prescaler == DIV_MAX);
        prescaler_next = tick ? '0 : prescaler + DIV_W'(1);
        mtime_next     = tick ? mtime + 64'd1 : mtime;
        mtimecmp_next  = mtimecmp;
        rdata_next     = '0;

        if (accept && !err_next) begin
            if (req_write) begin
                if (hit_time) begin
                    mtime_next = (mtime & ~wmask) | (req_wdata & wmask);
                end
                if (hit_cmp) begin
                    mtimecmp_next = (mtimecmp & ~wmask) | (req_wdata & wmask);
                end
            end else begin
                if (hit_time) begin
                    rdata_next = mtime;
                end
                if (hit_cmp) begin
                    rdata_next = mtimecmp;
                end
`ifdef CLINT_MSIP_EN
                if (hit_msip) begin
                    rdata_next = {63'd0, msip};
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime      <= '0;
            mtimecmp   <= '1;
            prescaler  <= '0;
            clint_mtip <= 1'b0;
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            mtime      <= mtime_next;
            mtimecmp   <= mtimecmp_next;
            prescaler  <= prescaler_next;
            clint_mtip <= (mtime_next >= mtimecmp_next);
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= RESP;
                        req_ready  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_next;
                        resp_err   <= err_next;
                    end
                end
                RESP: begin
                    // Returning to IDLE takes a full cycle so a new request is never taken alongside the handshake.
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLINT_MSIP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip <= 1'b0;
        end else if (accept && !err_next && req_write && hit_msip && req_wstrb[0]) begin
            msip <= req_wdata[0];
        end
    end

    assign clint_msip = msip;
`endif

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: a TICK_DIV=1 instance driven by randomized bus traffic
// against a cycle-indexed timer model, plus a TICK_DIV=4 instance for prescaler timing.
module tb_clint_timer;

    localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_CMP  = BASE + 64'h4000;
    localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
    localparam logic [63:0] A_MSIP = BASE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        clint_mtip;

    logic        req_valid4 = 1'b0;
    logic        req_ready4;
    logic        resp_valid4;
    logic [63:0] resp_rdata4;
    logic        resp_err4;
    logic        clint_mtip4;

`ifdef CLINT_MSIP_EN
    logic        clint_msip;
    logic        clint_msip4;
`endif

    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    // Timer model: mtime after posedge k is mt_base + (k - mt_base_cyc), wrapping at 64 bits.
    logic [63:0] mt_base = '0;
    int          mt_base_cyc = 0;
    logic [63:0] m_cmp = '1;
    logic        m_msip = 1'b0;

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1), .DIV_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .clint_mtip(clint_mtip)
`ifdef CLINT_MSIP_EN
        , .clint_msip(clint_msip)
`endif
    );

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(4), .DIV_W(8)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_write(1'b0),
        .req_addr(A_TIME), .req_wdata(64'd0), .req_wstrb(8'h00),
        .resp_valid(resp_valid4), .resp_ready(1'b1), .resp_rdata(resp_rdata4),
        .resp_err(resp_err4), .clint_mtip(clint_mtip4)
`ifdef CLINT_MSIP_EN
        , .clint_msip(clint_msip4)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mtime_at(input int k);
        return mt_base + 64'(k - mt_base_cyc);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] strb);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic addr_err(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        if (a[2:0] != 3'b000) return 1'b1;
        if (off == 64'h4000 || off == 64'hBFF8) return 1'b0;
`ifdef CLINT_MSIP_EN
        if (off == 64'h0000) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // One full transaction on the TICK_DIV=1 instance; returns at the negedge after the accept edge.
    task automatic bus_access(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [7:0] strb, input string tag,
                              output logic [63:0] rdata, output logic err);
        int          wait_cnt;
        int          acc;
        logic [63:0] off;
        logic [63:0] pre_mt;
        logic [63:0] exp_rdata;
        logic        exp_err;
        rdata = '0;
        err   = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        wait_cnt  = 0;
        while (req_ready !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s_accept_timeout req_ready=%b required 1", tag, req_ready);
            req_valid = 1'b0;
            return;
        end
        acc       = cyc + 1;
        off       = addr - BASE;
        exp_err   = addr_err(addr);
        exp_rdata = '0;
        pre_mt    = mtime_at(acc - 1);
        if (!exp_err) begin
            if (wr) begin
                if (off == 64'h4000) m_cmp = merge(m_cmp, wdata, strb);
                else if (off == 64'hBFF8) begin
                    mt_base     = merge(pre_mt, wdata, strb);
                    mt_base_cyc = acc;
                end else if (strb[0]) m_msip = wdata[0];
            end else begin
                if (off == 64'h4000) exp_rdata = m_cmp;
                else if (off == 64'hBFF8) exp_rdata = pre_mt;
                else exp_rdata = {63'd0, m_msip};
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        rdata = resp_rdata;
        err   = resp_err;
        checks++;
        if (resp_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s_resp_valid got %b required 1", tag, resp_valid);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_req_ready_in_resp got %b required 0", tag, req_ready);
        end
        checks++;
        if (resp_rdata !== exp_rdata) begin
            fails++;
            $display("[TB] FAIL %s_rdata got %h required %h", tag, resp_rdata, exp_rdata);
        end
        checks++;
        if (resp_err !== exp_err) begin
            fails++;
            $display("[TB] FAIL %s_err got %b required %b", tag, resp_err, exp_err);
        end
    endtask

    task automatic test_reset;
        logic [63:0] rd;
        logic        er;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (clint_mtip !== 1'b0 || clint_mtip4 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mtip got %b/%b required 0/0", clint_mtip, clint_mtip4);
        end
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_handshake got ready=%b valid=%b required 1/0", req_ready, resp_valid);
        end
        checks++;
        if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_resp got rdata=%h err=%b required 0/0", resp_rdata, resp_err);
        end
        rst = 1'b0;
        mt_base = '0;
        mt_base_cyc = cyc;
        m_cmp = '1;
        m_msip = 1'b0;
        bus_access(1'b0, A_TIME, 64'd0, 8'h00, "reset_rd_mtime", rd, er);
        checks++;
        if (rd > 64'd16) begin
            fails++;
            $display("[TB] FAIL reset_mtime_small got %0d required <=16", rd);
        end
        bus_access(1'b0, A_CMP, 64'd0, 8'h00, "reset_rd_cmp", rd, er);
        checks++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || er !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_cmp_value got %h err=%b required all-ones err=0", rd, er);
        end
    endtask

    task automatic test_compare;
        logic [63:0] rd;
        logic        er;
        int          rise;
        bus_access(1'b1, A_TIME, 64'd10, 8'hFF, "cmp_wr_mtime", rd, er);
        bus_access(1'b1, A_CMP, 64'd20, 8'hFF, "cmp_wr_cmp", rd, er);
        rise = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (clint_mtip !== (mtime_at(cyc) >= m_cmp)) begin
                fails++;
                $display("[TB] FAIL cmp_mtip mtime=%0d got %b required %b", mtime_at(cyc), clint_mtip, mtime_at(cyc) >= m_cmp);
            end
            if (clint_mtip === 1'b1 && rise < 0) rise = cyc;
        end
        checks++;
        if (rise < 0 || mtime_at(rise) !== 64'd20) begin
            fails++;
            $display("[TB] FAIL cmp_rise_point got mtime=%0d required 20", (rise < 0) ? 64'd0 : mtime_at(rise));
        end
        bus_access(1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "cmp_restore", rd, er);
    endtask

    task automatic test_byte_mask;
        logic [63:0] rd;
        logic        er;
        logic [63:0] d;
        logic [7:0]  s;
        bus_access(1'b1, A_CMP, 64'h0000_0000_0000_00AB, 8'h01, "mask_wr", rd, er);
        bus_access(1'b0, A_CMP, 64'd0, 8'h00, "mask_rd", rd, er);
        checks++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFAB) begin
            fails++;
            $display("[TB] FAIL mask_value got %h required ffffffffffffffab", rd);
        end
        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom};
            s = 8'($urandom);
            bus_access(1'b1, A_CMP, d, s, "mask_rand_wr", rd, er);
            bus_access(1'b0, A_CMP, 64'd0, 8'h00, "mask_rand_rd", rd, er);
            checks++;
            if (clint_mtip !== (mtime_at(cyc) >= m_cmp)) begin
                fails++;
                $display("[TB] FAIL mask_mtip got %b required %b", clint_mtip, mtime_at(cyc) >= m_cmp);
            end
        end
        bus_access(1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "mask_restore", rd, er);
    endtask

    task automatic test_mtime_write;
        logic [63:0] rd;
        logic        er;
        int          n;
        for (int i = 0; i < 3; i++) begin
            n = int'($urandom_range(1, 10));
            bus_access(1'b1, A_TIME, 64'h100, 8'hFF, "mt_wr", rd, er);
            repeat (n) @(negedge clk);
            bus_access(1'b0, A_TIME, 64'd0, 8'h00, "mt_rd", rd, er);
            checks++;
            if (rd !== 64'h100 + 64'(n) + 64'd1) begin
                fails++;
                $display("[TB] FAIL mt_elapsed got %h required %h", rd, 64'h100 + 64'(n) + 64'd1);
            end
        end
        bus_access(1'b1, A_TIME, {$urandom, $urandom}, 8'($urandom), "mt_partial_wr", rd, er);
        bus_access(1'b0, A_TIME, 64'd0, 8'h00, "mt_partial_rd", rd, er);
        bus_access(1'b1, A_TIME, 64'd500, 8'hFF, "mt_restore", rd, er);
    endtask

    task automatic test_err_stall;
        logic [63:0] rd;
        logic [63:0] cmp_before;
        logic        er;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = BASE + 64'h8000;
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stall_idle_ready got %b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 64'd0 || req_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stall_hold cycle %0d got valid=%b err=%b rdata=%h ready=%b required 1/1/0/0",
                         i, resp_valid, resp_err, resp_rdata, req_ready);
            end
            if (i == 2) resp_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stall_release got valid=%b ready=%b required 0/1", resp_valid, req_ready);
        end
        bus_access(1'b0, A_CMP + 64'd4, 64'd0, 8'h00, "err_misaligned", rd, er);
        checks++;
        if (er !== 1'b1) begin
            fails++;
            $display("[TB] FAIL err_misaligned_flag got %b required 1", er);
        end
        cmp_before = m_cmp;
        bus_access(1'b1, BASE + 64'h8000, 64'd0, 8'hFF, "err_wr", rd, er);
        bus_access(1'b1, A_CMP + 64'd1, 64'd0, 8'hFF, "err_wr_misaligned", rd, er);
        bus_access(1'b0, A_CMP, 64'd0, 8'h00, "err_cmp_intact", rd, er);
        checks++;
        if (rd !== cmp_before) begin
            fails++;
            $display("[TB] FAIL err_no_write got %h required %h", rd, cmp_before);
        end
    endtask

    task automatic test_wrap;
        logic [63:0] rd;
        logic        er;
        int          falls;
        falls = 0;
        bus_access(1'b1, A_CMP, 64'd1, 8'hFF, "wrap_cmp", rd, er);
        bus_access(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, "wrap_mtime", rd, er);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (clint_mtip !== (mtime_at(cyc) >= m_cmp)) begin
                fails++;
                $display("[TB] FAIL wrap_mtip mtime=%h got %b required %b", mtime_at(cyc), clint_mtip, mtime_at(cyc) >= m_cmp);
            end
            if (mtime_at(cyc) == 64'd0 && clint_mtip === 1'b0) falls++;
        end
        checks++;
        if (falls != 1) begin
            fails++;
            $display("[TB] FAIL wrap_zero_low got %0d low-at-zero cycles required 1", falls);
        end
        bus_access(1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "wrap_restore", rd, er);
    endtask

    task automatic test_back_to_back;
        logic [63:0] rd;
        logic        er;
        logic [63:0] addr;
        logic [63:0] d;
        logic        wr;
        int          pick;
        for (int i = 0; i < 20; i++) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
                0: addr = A_CMP;
                1: addr = A_TIME;
                2: addr = BASE + 64'h4008;
                3: addr = A_TIME + 64'd2;
                4: addr = A_MSIP;
                default: addr = A_CMP;
            endcase
            wr = 1'($urandom);
            d  = mtime_at(cyc) + 64'($urandom_range(0, 8));
            bus_access(wr, addr, d, (pick == 5) ? 8'($urandom) : 8'hFF, "b2b", rd, er);
            checks++;
            if (clint_mtip !== (mtime_at(cyc) >= m_cmp)) begin
                fails++;
                $display("[TB] FAIL b2b_mtip got %b required %b", clint_mtip, mtime_at(cyc) >= m_cmp);
            end
        end
        bus_access(1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "b2b_restore", rd, er);
    endtask

    task automatic rd4(input int edge_no, output logic [63:0] val);
        while (cyc < edge_no - 1) @(negedge clk);
        req_valid4 = 1'b1;
        checks++;
        if (req_ready4 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL div4_ready got %b required 1", req_ready4);
        end
        @(negedge clk);
        req_valid4 = 1'b0;
        val = resp_rdata4;
    endtask

    task automatic test_tick_div;
        logic [63:0] v0;
        logic [63:0] vk;
        int          e0;
        e0 = cyc + 3;
        rd4(e0, v0);
        for (int k = 1; k <= 10; k++) begin
            rd4(e0 + 4 * k, vk);
            checks++;
            if (vk - v0 !== 64'(k)) begin
                fails++;
                $display("[TB] FAIL div4_advance after %0d clk got %0d ticks required %0d", 4 * k, vk - v0, k);
            end
        end
        checks++;
        if (resp_err4 !== 1'b0 || clint_mtip4 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL div4_flags got err=%b mtip=%b required 0/0", resp_err4, clint_mtip4);
        end
    endtask

    task automatic test_msip;
        logic [63:0] rd;
        logic        er;
`ifdef CLINT_MSIP_EN
        bus_access(1'b1, A_MSIP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "msip_wr1", rd, er);
        checks++;
        if (clint_msip !== 1'b1) begin
            fails++;
            $display("[TB] FAIL msip_set got %b required 1", clint_msip);
        end
        bus_access(1'b0, A_MSIP, 64'd0, 8'h00, "msip_rd1", rd, er);
        bus_access(1'b1, A_MSIP, 64'd0, 8'hFF, "msip_wr0", rd, er);
        checks++;
        if (clint_msip !== 1'b0) begin
            fails++;
            $display("[TB] FAIL msip_clear got %b required 0", clint_msip);
        end
`else
        bus_access(1'b1, A_MSIP, 64'd1, 8'hFF, "msip_off_wr", rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 64'd0) begin
            fails++;
            $display("[TB] FAIL msip_off_err got err=%b rdata=%h required 1/0", er, rd);
        end
`endif
    endtask

    task automatic test_reset_mid;
        logic [63:0] rd;
        logic        er;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = A_TIME;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || clint_mtip !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_async got valid=%b ready=%b mtip=%b required 0/1/0", resp_valid, req_ready, clint_mtip);
        end
        @(negedge clk);
        rst = 1'b0;
        mt_base = '0;
        mt_base_cyc = cyc;
        m_cmp = '1;
        m_msip = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL midreset_no_resp got %b required 0", resp_valid);
            end
        end
        bus_access(1'b0, A_TIME, 64'd0, 8'h00, "midreset_rd", rd, er);
    endtask

    initial begin
        test_reset();
        test_compare();
        test_byte_mask();
        test_mtime_write();
        test_err_stall();
        test_wrap();
        test_back_to_back();
        test_tick_div();
        test_msip();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
